// File: rtl/phase_unwrap_pkg.sv
// phase_unwrap_pkg: shared constants, wrap-step encoding and arithmetic helpers for the phase unwrapper.
package phase_unwrap_pkg;

    localparam int PI_Q_DEF     = 6588397;
    localparam int TWO_PI_Q_DEF = 13176795;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN
    } step_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide operands keep the raw sum exact so callers can detect clipping by comparison.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (s > hi) ? hi : ((s < lo) ? lo : s);
    endfunction

endpackage

// File: rtl/phase_unwrap_core.sv
// phase_unwrap_core: per-channel wrap decision and candidate offset, combinational on one sample.
module phase_unwrap_core
    import phase_unwrap_pkg::*;
#(
    parameter int IN_W     = 24,
    parameter int OUT_W    = 32,
    parameter int PI_Q     = PI_Q_DEF,
    parameter int TWO_PI_Q = TWO_PI_Q_DEF
) (
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [IN_W-1:0]  prev,
    input  logic signed [OUT_W-1:0] off,
    input  logic                    first,
    output logic signed [OUT_W:0]   off_new,
    output step_t                   step
);

    localparam logic signed [IN_W:0]  PI_L  = (IN_W + 1)'(PI_Q);
    localparam logic signed [OUT_W:0] TWO_L = (OUT_W + 1)'(TWO_PI_Q);

    logic signed [IN_W:0]  dp;
    logic signed [OUT_W:0] off_ext;

    // One extra bit on the offset lets the caller see a step that would leave the OUT_W range.
    always_comb begin
        dp      = {x[IN_W-1], x} - {prev[IN_W-1], prev};
        off_ext = {off[OUT_W-1], off};
        step    = !first ? STEP_NONE : (dp > PI_L) ? STEP_DN : (dp < -PI_L) ? STEP_UP : STEP_NONE;
        off_new = (step == STEP_DN) ? off_ext - TWO_L : (step == STEP_UP) ? off_ext + TWO_L : off_ext;
    end

endmodule

// File: rtl/phase_unwrap_mc.sv
// phase_unwrap_mc: multi-channel AXI-Stream phase unwrapper with saturation and frame checking.
// Define PHASE_UNWRAP_WRAPCNT_EN to add the per-channel signed wrap_cnt output.
module phase_unwrap_mc
    import phase_unwrap_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int IN_W     = 24,
    parameter int OUT_W    = 32,
    parameter int FRAC     = 21,
    parameter int PI_Q     = PI_Q_DEF,
    parameter int TWO_PI_Q = TWO_PI_Q_DEF
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [IN_W-1:0]           S_AXIS_tdata,
    input  logic                      S_AXIS_tvalid,
    input  logic                      S_AXIS_tlast,
    output logic                      S_AXIS_tready,
    output logic [OUT_W-1:0]          M_AXIS_tdata,
    output logic [ch_w(N_CH)-1:0]     M_AXIS_tuser,
    output logic                      M_AXIS_tlast,
    output logic                      M_AXIS_tvalid,
    input  logic                      M_AXIS_tready,
    output logic [N_CH-1:0]           sat_flag,
    output logic                      frame_err
`ifdef PHASE_UNWRAP_WRAPCNT_EN
    ,
    output logic [N_CH*16-1:0]        wrap_cnt
`endif
);

    localparam int CW = ch_w(N_CH);

    if (OUT_W <= IN_W || FRAC >= IN_W) begin : g_bad_cfg
        $error("phase_unwrap_mc: OUT_W must exceed IN_W and FRAC must be below IN_W");
    end

    logic signed [IN_W-1:0]  prev [N_CH];
    logic signed [OUT_W-1:0] off  [N_CH];
    logic [N_CH-1:0]         first;
    logic [CW-1:0]           ch;

    logic                    s1_v;
    logic                    s1_last;
    logic [CW-1:0]           s1_ch;
    logic signed [OUT_W-1:0] s1_y;

    logic                    adv;
    logic                    acc;
    logic                    ch_end;
    logic                    mismatch;
    logic                    clip;
    logic signed [IN_W-1:0]  x;
    logic signed [OUT_W:0]   off_new;
    step_t                   step;
    logic signed [63:0]      sum_raw;
    logic signed [63:0]      sum_sat;
    logic signed [OUT_W-1:0] y;
    logic signed [OUT_W-1:0] off_commit;

    assign x             = S_AXIS_tdata;
    assign adv           = !M_AXIS_tvalid || M_AXIS_tready;
    assign S_AXIS_tready = !reset && (!s1_v || adv);
    assign acc           = S_AXIS_tvalid && S_AXIS_tready;

    phase_unwrap_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .PI_Q     (PI_Q),
        .TWO_PI_Q (TWO_PI_Q)
    ) u_core (
        .x       (x),
        .prev    (prev[ch]),
        .off     (off[ch]),
        .first   (first[ch]),
        .off_new (off_new),
        .step    (step)
    );

    // Saturation is resolved at acceptance so a clipped step never reaches the offset
    // register that the very next beat of the same channel reads.
    always_comb begin
        ch_end     = int'(ch) == N_CH - 1;
        mismatch   = S_AXIS_tlast != ch_end;
        sum_raw    = 64'(x) + 64'(off_new);
        sum_sat    = sat_add(64'(x), 64'(off_new), OUT_W);
        clip       = enable && ((sum_sat != sum_raw) || (off_new[OUT_W] != off_new[OUT_W-1]));
        y          = enable ? OUT_W'(sum_sat) : OUT_W'(x);
        off_commit = clip ? off[ch] : OUT_W'(off_new);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            ch            <= '0;
            first         <= '0;
            s1_v          <= 1'b0;
            s1_last       <= 1'b0;
            s1_ch         <= '0;
            s1_y          <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tuser  <= '0;
            M_AXIS_tlast  <= 1'b0;
            sat_flag      <= '0;
            frame_err     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                off[i]  <= '0;
                prev[i] <= '0;
            end
        end else begin
            if (adv) begin
                M_AXIS_tvalid <= s1_v;
                M_AXIS_tdata  <= s1_y;
                M_AXIS_tuser  <= s1_ch;
                M_AXIS_tlast  <= s1_last;
            end
            if (acc) begin
                s1_v      <= 1'b1;
                s1_y      <= y;
                s1_ch     <= ch;
                s1_last   <= S_AXIS_tlast;
                ch        <= (S_AXIS_tlast || ch_end) ? '0 : ch + CW'(1);
                prev[ch]  <= x;
                frame_err <= frame_err | mismatch;
                if (clip) sat_flag[ch] <= 1'b1;
            end else if (adv) begin
                s1_v <= 1'b0;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (!enable) begin
                    off[i]   <= '0;
                    first[i] <= 1'b0;
                end else if (acc && int'(ch) == i) begin
                    off[i]   <= off_commit;
                    first[i] <= 1'b1;
                end
            end
        end
    end

`ifdef PHASE_UNWRAP_WRAPCNT_EN
    logic signed [15:0] wc [N_CH];

    always_ff @(posedge aclk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (reset || !enable)
                wc[i] <= '0;
            else if (acc && !clip && int'(ch) == i)
                wc[i] <= (step == STEP_UP && wc[i] != 16'sd32767) ? wc[i] + 16'sd1 :
                         (step == STEP_DN && wc[i] != -16'sd32767) ? wc[i] - 16'sd1 : wc[i];
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_wc
        assign wrap_cnt[k*16 +: 16] = wc[k];
    end
`endif

endmodule

// File: tb/tb_phase_unwrap_mc.sv
// tb_phase_unwrap_mc: directed checks of phase_unwrap_mc on a 1-channel/26-bit and a 2-channel/32-bit instance.
module tb_phase_unwrap_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint d;
        int     u;
        bit     l;
    } beat_t;

    beat_t a_q[$];
    beat_t b_q[$];
    int    b_acc = 0;

    logic        a_rst, a_en, a_sv, a_sl, a_sr, a_mv, a_ml, a_mr, a_fe;
    logic [23:0] a_sd;
    logic [25:0] a_md;
    logic [0:0]  a_mu, a_sat;

    logic        b_rst, b_en, b_sv, b_sl, b_sr, b_mv, b_ml, b_mr, b_fe;
    logic [23:0] b_sd;
    logic [31:0] b_md;
    logic [0:0]  b_mu;
    logic [1:0]  b_sat;

`ifdef PHASE_UNWRAP_WRAPCNT_EN
    logic [15:0] a_wc;
    logic [31:0] b_wc;
`endif

    phase_unwrap_mc #(.N_CH(1), .OUT_W(26)) u_a (
        .aclk(clk), .reset(a_rst), .enable(a_en),
        .S_AXIS_tdata(a_sd), .S_AXIS_tvalid(a_sv), .S_AXIS_tlast(a_sl), .S_AXIS_tready(a_sr),
        .M_AXIS_tdata(a_md), .M_AXIS_tuser(a_mu), .M_AXIS_tlast(a_ml), .M_AXIS_tvalid(a_mv),
        .M_AXIS_tready(a_mr), .sat_flag(a_sat), .frame_err(a_fe)
`ifdef PHASE_UNWRAP_WRAPCNT_EN
        , .wrap_cnt(a_wc)
`endif
    );

    phase_unwrap_mc #(.N_CH(2), .OUT_W(32)) u_b (
        .aclk(clk), .reset(b_rst), .enable(b_en),
        .S_AXIS_tdata(b_sd), .S_AXIS_tvalid(b_sv), .S_AXIS_tlast(b_sl), .S_AXIS_tready(b_sr),
        .M_AXIS_tdata(b_md), .M_AXIS_tuser(b_mu), .M_AXIS_tlast(b_ml), .M_AXIS_tvalid(b_mv),
        .M_AXIS_tready(b_mr), .sat_flag(b_sat), .frame_err(b_fe)
`ifdef PHASE_UNWRAP_WRAPCNT_EN
        , .wrap_cnt(b_wc)
`endif
    );

    always @(negedge clk) begin
        if (a_mv && a_mr) a_q.push_back('{$signed(a_md), int'(a_mu), a_ml});
        if (b_mv && b_mr) b_q.push_back('{$signed(b_md), int'(b_mu), b_ml});
        if (b_sv && b_sr) b_acc++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_a(input longint x, input bit en);
        bit ok = 0;
        a_sd = 24'(x);
        a_sl = 1'b1;
        a_en = en;
        a_sv = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = a_sr;
        end
        if (!ok) check("a_send_timeout", 0, 1);
        @(posedge clk);
        #1;
        a_sv = 1'b0;
    endtask

    task automatic send_b(input longint x, input bit last);
        bit ok = 0;
        b_sd = 24'(x);
        b_sl = last;
        b_sv = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = b_sr;
        end
        if (!ok) check("b_send_timeout", 0, 1);
        @(posedge clk);
        #1;
        b_sv = 1'b0;
    endtask

    task automatic wait_a(input int n);
        for (int i = 0; i < 100 && a_q.size() < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input int n);
        for (int i = 0; i < 100 && b_q.size() < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input longint d);
        beat_t t;
        if (a_q.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
            return;
        end
        t = a_q.pop_front();
        check(tag, t.d, d);
    endtask

    task automatic chk_b(input string tag, input longint d, input int u, input bit l);
        beat_t t;
        if (b_q.size() == 0) begin
            check({tag, "_missing"}, 0, 1);
            return;
        end
        t = b_q.pop_front();
        check(tag, t.d, d);
        check({tag, "_tuser"}, t.u, u);
        check({tag, "_tlast"}, t.l, l);
    endtask

    task automatic rst_a();
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        a_q.delete();
    endtask

    task automatic rst_b();
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        b_q.delete();
        b_acc = 0;
    endtask

    initial begin
        longint v, x;
        a_rst = 1; a_en = 1; a_sv = 0; a_sl = 1; a_sd = '0; a_mr = 1;
        b_rst = 1; b_en = 1; b_sv = 0; b_sl = 0; b_sd = '0; b_mr = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_tvalid", a_mv, 0);
        check("rst_a_tdata", a_md, 0);
        check("rst_a_sat", a_sat, 0);
        check("rst_b_tvalid", b_mv, 0);
        check("rst_b_tdata", b_md, 0);
        check("rst_b_frame_err", b_fe, 0);
        a_rst = 0;
        b_rst = 0;

        send_a(6000000, 1);
        send_a(-6000000, 1);
        wait_a(2);
        chk_a("wrap0", 6000000);
        chk_a("wrap1", 7176795);

        rst_a();
        send_a(0, 1);
        send_a(6588397, 1);
        wait_a(2);
        chk_a("pi_edge0", 0);
        chk_a("pi_edge1", 6588397);

        rst_a();
        for (int k = 0; k <= 16; k++) begin
            v = longint'(k) * 2097152;
            x = v;
            while (x > 6588397) x -= 13176795;
            send_a(x, 1);
        end
        wait_a(17);
        for (int k = 0; k <= 16; k++)
            chk_a($sformatf("ramp%0d", k), (k < 16) ? longint'(k) * 2097152 : 33554431);
        check("ramp_sat_flag", a_sat, 1);
        check("ramp_frame_err", a_fe, 0);

        send_a(12345, 0);
        send_a(-777, 1);
        wait_a(2);
        chk_a("enable_low_pass", 12345);
        chk_a("enable_rise_first", -777);
        check("sat_sticky", a_sat, 1);

        send_a(1000, 1);
        send_a(2000, 1);
        a_sd = 24'(3000);
        a_sv = 1'b1;
        a_rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_tvalid", a_mv, 0);
        check("midrst_tdata", a_md, 0);
        check("midrst_tuser", a_mu, 0);
        check("midrst_tlast", a_ml, 0);
        check("midrst_sat", a_sat, 0);
        check("midrst_frame_err", a_fe, 0);
        check("midrst_tready", a_sr, 0);
        a_rst = 1'b0;
        a_sv = 1'b0;
        a_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("midrst_flushed", a_q.size(), 0);

        send_b(6000000, 0);
        send_b(100, 1);
        send_b(-6000000, 0);
        send_b(100, 1);
        wait_b(4);
        chk_b("il0", 6000000, 0, 0);
        chk_b("il1", 100, 1, 1);
        chk_b("il2", 7176795, 0, 0);
        chk_b("il3", 100, 1, 1);
        check("il_frame_err", b_fe, 0);

        rst_b();
        b_mr = 1'b0;
        fork
            begin
                send_b(100, 0);
                send_b(200, 1);
                send_b(300, 0);
                send_b(400, 1);
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                check("stall_tready", b_sr, 0);
                check("stall_buffered", b_acc, 2);
                b_mr = 1'b1;
            end
        join
        wait_b(4);
        chk_b("stall0", 100, 0, 0);
        chk_b("stall1", 200, 1, 1);
        chk_b("stall2", 300, 0, 0);
        chk_b("stall3", 400, 1, 1);
        repeat (5) @(posedge clk);
        #1;
        check("stall_no_dup", b_q.size(), 0);

        rst_b();
        send_b(500, 1);
        send_b(600, 0);
        wait_b(2);
        chk_b("ferr0", 500, 0, 1);
        chk_b("ferr1", 600, 0, 0);
        check("frame_err_set", b_fe, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
